// File: rtl/mat_axis_pkg.sv
// Shared definitions for the mat-stream to AXI-stream packer:
// FSM state encoding, a constant-friendly clog2 and default geometry.
package mat_axis_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_ROWFLUSH,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Default geometry: 3 x 8-bit pixels per beat into 64-bit words.
  localparam int PIXW_DEFAULT  = 8;
  localparam int NPC_DEFAULT   = 3;
  localparam int DATAW_DEFAULT = 64;
  localparam int BEATW = NPC_DEFAULT * PIXW_DEFAULT;
  localparam int ACCW  = DATAW_DEFAULT + BEATW;

endpackage

// File: rtl/mat_axis_bitpacker.sv
// Combinational bit packer: appends the valid low bits of one beat above
// the current fill level of the accumulator and reports whether a full
// output word is now available.
module mat_axis_bitpacker
  import mat_axis_pkg::*;
#(
  parameter int PIXW  = 8,
  parameter int NPC   = 3,
  parameter int DATAW = 64
) (
  input  logic [DATAW+NPC*PIXW-1:0]       acc,
  input  logic [clog2(DATAW+1)-1:0]       fill,
  input  logic [NPC*PIXW-1:0]             beat,
  input  logic [clog2(NPC*PIXW+1)-1:0]    vbits,
  output logic [DATAW+NPC*PIXW-1:0]       cand,
  output logic                            emit,
  output logic [clog2(DATAW+1)-1:0]       next_fill
);

  localparam int BEAT_W = NPC * PIXW;
  localparam int ACC_W  = DATAW + BEAT_W;
  localparam int FILL_W = clog2(DATAW + 1);
  localparam int SUM_W  = FILL_W + 1;

  logic [BEAT_W-1:0] beat_mask;
  logic [BEAT_W-1:0] beat_valid;
  logic [ACC_W-1:0]  beat_ext;
  logic [SUM_W-1:0]  fill_sum;

  // Mask off unused pixels, shift above the fill level and merge.
  always_comb begin
    beat_mask  = ~({BEAT_W{1'b1}} << vbits);
    beat_valid = beat & beat_mask;
    beat_ext   = {{DATAW{1'b0}}, beat_valid};
    cand       = acc | (beat_ext << fill);
    fill_sum   = SUM_W'(fill) + SUM_W'(vbits);
    emit       = (fill_sum >= SUM_W'(DATAW));
    next_fill  = emit ? FILL_W'(fill_sum - SUM_W'(DATAW)) : FILL_W'(fill_sum);
  end

endmodule

// File: rtl/mat_stream_axis_packer.sv
// Mat-stream to AXI-stream packer with ap_ctrl_chain handshake.
// Packs NPC-pixel beats LSB-first into DATAW-bit words, honours a partial
// last block per row and flushes a zero-padded tail word at end of frame.
// Optional macro MS2AS_ROW_ALIGN_EN: flush residual bits at every row end
// and mark the final word of each row with out_last.
module mat_stream_axis_packer
  import mat_axis_pkg::*;
#(
  parameter int PIXW  = 8,
  parameter int NPC   = 3,
  parameter int DATAW = 64,
  parameter int ROWW  = 16,
  parameter int COLW  = 16
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  input  logic                        ap_continue,
  output logic                        ap_done,
  output logic                        ap_idle,
  output logic                        ap_ready,
  input  logic [NPC*PIXW-1:0]         in_dout,
  input  logic                        in_empty_n,
  output logic                        in_read,
  output logic [DATAW-1:0]            out_din,
  input  logic                        out_full_n,
  output logic                        out_write,
`ifdef MS2AS_ROW_ALIGN_EN
  output logic                        out_last,
`endif
  input  logic [ROWW-1:0]             rows_dout,
  input  logic                        rows_empty_n,
  output logic                        rows_read,
  input  logic [COLW-1:0]             cols_dout,
  input  logic                        cols_empty_n,
  output logic                        cols_read,
  input  logic [clog2(NPC+1)-1:0]     last_blk_width
);

  localparam int BEAT_W = NPC * PIXW;
  localparam int ACC_W  = DATAW + BEAT_W;
  localparam int FILL_W = clog2(DATAW + 1);
  localparam int VB_W   = clog2(BEAT_W + 1);
  localparam int LBW_W  = clog2(NPC + 1);

  if (NPC * PIXW > DATAW) begin : g_width_check
    $error("mat_stream_axis_packer: NPC*PIXW must not exceed DATAW");
  end

  state_t             state_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [FILL_W-1:0]  fill_reg;
  logic [ROWW-1:0]    row_reg;
  logic [COLW-1:0]    col_reg;
  logic [ROWW-1:0]    rows_reg;
  logic [COLW-1:0]    cols_reg;
  logic [LBW_W-1:0]   lbw_reg;
  logic               done_reg;

  logic [ACC_W-1:0]   cand;
  logic               emit;
  logic [FILL_W-1:0]  next_fill;
  logic [VB_W-1:0]    vbits;
  logic               last_col;
  logic               last_row;
  logic               start_ok;
  logic               beat_take;
  logic               flush_write;
  logic [LBW_W-1:0]   lbw_latch;

  mat_axis_bitpacker #(
    .PIXW (PIXW),
    .NPC  (NPC),
    .DATAW(DATAW)
  ) u_bitpacker (
    .acc      (acc_reg),
    .fill     (fill_reg),
    .beat     (in_dout),
    .vbits    (vbits),
    .cand     (cand),
    .emit     (emit),
    .next_fill(next_fill)
  );

  // Handshake decode: beat width, pops, pushes and the outgoing word.
  always_comb begin
    last_col    = (col_reg == cols_reg - COLW'(1));
    last_row    = (row_reg == rows_reg - ROWW'(1));
    vbits       = last_col ? VB_W'(int'(lbw_reg) * PIXW) : VB_W'(BEAT_W);
    lbw_latch   = (last_blk_width == '0 || int'(last_blk_width) > NPC)
                  ? LBW_W'(NPC) : last_blk_width;
    start_ok    = (state_reg == ST_IDLE) && ap_start && rows_empty_n &&
                  cols_empty_n && !done_reg;
    beat_take   = (state_reg == ST_RUN) && in_empty_n && !(emit && !out_full_n);
    flush_write = (state_reg == ST_FLUSH || state_reg == ST_ROWFLUSH) &&
                  (fill_reg != '0) && out_full_n;
    rows_read   = start_ok;
    cols_read   = start_ok;
    in_read     = beat_take;
    out_write   = (beat_take && emit) || flush_write;
    out_din     = '0;
    if (state_reg == ST_RUN && emit)
      out_din = cand[DATAW-1:0];
    else if ((state_reg == ST_FLUSH || state_reg == ST_ROWFLUSH) && fill_reg != '0)
      out_din = acc_reg[DATAW-1:0];
    ap_done     = done_reg;
    ap_ready    = (state_reg == ST_DONE);
    ap_idle     = (state_reg == ST_IDLE) && !ap_start;
  end

`ifdef MS2AS_ROW_ALIGN_EN
  // Final word of a row: an exact fill on the row's last beat, or a flush.
  always_comb begin
    out_last = (beat_take && emit && last_col && next_fill == '0) || flush_write;
  end
`endif

  // Frame FSM, accumulator and row/column counters.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      fill_reg  <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      rows_reg  <= '0;
      cols_reg  <= '0;
      lbw_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      if (ap_continue)
        done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            rows_reg <= rows_dout;
            cols_reg <= cols_dout;
            lbw_reg  <= lbw_latch;
            row_reg  <= '0;
            col_reg  <= '0;
            acc_reg  <= '0;
            fill_reg <= '0;
            if (rows_dout == '0 || cols_dout == '0) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (beat_take) begin
            acc_reg  <= emit ? (cand >> DATAW) : cand;
            fill_reg <= next_fill;
            if (last_col) begin
              col_reg <= '0;
              row_reg <= row_reg + ROWW'(1);
              if (last_row)
                state_reg <= ST_FLUSH;
`ifdef MS2AS_ROW_ALIGN_EN
              else if (next_fill != '0)
                state_reg <= ST_ROWFLUSH;
`endif
            end else begin
              col_reg <= col_reg + COLW'(1);
            end
          end
        end
        ST_ROWFLUSH: begin
          if (out_full_n) begin
            acc_reg   <= '0;
            fill_reg  <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (fill_reg == '0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else if (out_full_n) begin
            acc_reg   <= '0;
            fill_reg  <= '0;
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mat_stream_axis_packer.sv
// Scoreboard bench for mat_stream_axis_packer: expected words come from a
// bit-queue reference model or from literal constants; a monitor compares
// every pushed word in order. Honours MS2AS_ROW_ALIGN_EN when defined.
module tb_mat_stream_axis_packer;

  localparam int PIXW  = 8;
  localparam int NPC   = 3;
  localparam int DATAW = 64;
  localparam int ROWW  = 16;
  localparam int COLW  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic ap_start, ap_continue, ap_done, ap_idle, ap_ready;
  logic [NPC*PIXW-1:0] in_dout;
  logic in_empty_n, in_read;
  logic [DATAW-1:0] out_din;
  logic out_full_n, out_write;
`ifdef MS2AS_ROW_ALIGN_EN
  logic out_last;
`endif
  logic [ROWW-1:0] rows_dout;
  logic rows_empty_n, rows_read;
  logic [COLW-1:0] cols_dout;
  logic cols_empty_n, cols_read;
  logic [1:0] last_blk_width;

  always #5 clk = ~clk;

  mat_stream_axis_packer #(
    .PIXW(PIXW), .NPC(NPC), .DATAW(DATAW), .ROWW(ROWW), .COLW(COLW)
  ) dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .in_dout(in_dout), .in_empty_n(in_empty_n), .in_read(in_read),
    .out_din(out_din), .out_full_n(out_full_n), .out_write(out_write),
`ifdef MS2AS_ROW_ALIGN_EN
    .out_last(out_last),
`endif
    .rows_dout(rows_dout), .rows_empty_n(rows_empty_n), .rows_read(rows_read),
    .cols_dout(cols_dout), .cols_empty_n(cols_empty_n), .cols_read(cols_read),
    .last_blk_width(last_blk_width)
  );

  // Stimulus beats and expected words, indexed by running counters.
  logic [23:0] beat_mem [0:4095];
  logic [63:0] exp_mem  [0:1023];
  bit          exp_last_mem [0:1023];
  int beat_wr = 0, beat_rd = 0, beat_floor = 0;
  int exp_wr = 0, exp_rd = 0, exp_floor = 0;
  int cfg_wr = 0, cfg_rd = 0;
  bit gap_en = 0, bp_rand = 0, force_full = 0;
  int errors = 0, checks = 0;
  bit mq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Input-side FIFO models: pop on a sampled read, then present the next entry.
  initial begin
    bit take_in, take_cfg;
    in_dout = '0; in_empty_n = 0; out_full_n = 1; rows_empty_n = 0; cols_empty_n = 0;
    forever begin
      @(negedge clk);
      take_in  = in_read;
      take_cfg = rows_read;
      @(posedge clk);
      #1;
      if (take_in) beat_rd++;
      if (beat_rd < beat_floor) beat_rd = beat_floor;
      if (take_cfg) cfg_rd++;
      rows_empty_n = (cfg_rd != cfg_wr);
      cols_empty_n = (cfg_rd != cfg_wr);
      in_empty_n = (beat_rd < beat_wr) && (!gap_en || $urandom_range(0, 3) != 0);
      in_dout = (beat_rd < beat_wr) ? beat_mem[beat_rd] : 24'($urandom);
      out_full_n = force_full ? 1'b0 : (bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Output monitor: every accepted push is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_rd < exp_floor) exp_rd = exp_floor;
      if (rst_n) begin
        if (in_read) chk("read_while_empty", 64'(in_empty_n), 64'(1));
        if (out_write) begin
          chk("write_while_full", 64'(out_full_n), 64'(1));
          if (exp_rd >= exp_wr) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %h expected no write", out_din);
          end else begin
            $display("write %0d: %h", exp_rd, out_din);
            chk("word", out_din, exp_mem[exp_rd]);
`ifdef MS2AS_ROW_ALIGN_EN
            chk("out_last", 64'(out_last), 64'(exp_last_mem[exp_rd]));
`endif
            exp_rd++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic push_exp(input logic [63:0] w, input bit last);
    exp_mem[exp_wr] = w;
    exp_last_mem[exp_wr] = last;
    exp_wr++;
  endtask

  task automatic add_beat(input logic [23:0] b);
    beat_mem[beat_wr] = b;
    beat_wr++;
  endtask

  // mode 1: bytes 0,1,2,... ; otherwise random.
  task automatic load_beats(input int n, input int mode, output int first);
    first = beat_wr;
    for (int i = 0; i < n; i++) begin
      if (mode == 1) add_beat({8'(3*i+2), 8'(3*i+1), 8'(3*i)});
      else add_beat(24'($urandom));
    end
  endtask

  task automatic take_word(input bit last);
    logic [63:0] w;
    int n;
    w = '0;
    n = (mq.size() > 64) ? 64 : mq.size();
    for (int k = 0; k < n; k++) w[k] = mq.pop_front();
    push_exp(w, last);
  endtask

  // Reference: serialise valid pixel bits LSB-first, cut into 64-bit words.
  task automatic model_frame(input int first, input int rows, input int cols, input int lbw);
    int eff, np;
    logic [23:0] b;
    eff = (lbw == 0 || lbw > NPC) ? NPC : lbw;
    mq.delete();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        b = beat_mem[first + r*cols + c];
        np = (c == cols - 1) ? eff : NPC;
        for (int p = 0; p < np; p++)
          for (int k = 0; k < PIXW; k++) mq.push_back(b[p*PIXW + k]);
        while (mq.size() >= 64) take_word(0);
      end
`ifdef MS2AS_ROW_ALIGN_EN
      if (mq.size() > 0) take_word(1);
      else exp_last_mem[exp_wr-1] = 1;
`endif
    end
    if (mq.size() > 0) take_word(0);
  endtask

  task automatic start_frame(input int rows, input int cols, input int lbw);
    bit seen;
    rows_dout = ROWW'(rows);
    cols_dout = COLW'(cols);
    last_blk_width = 2'(lbw);
    cfg_wr++;
    ap_start = 1;
    seen = 0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (rows_read) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL start_pop: got no rows_read expected rows_read within 50 cycles");
    end
    @(posedge clk);
    #1 ap_start = 0;
  endtask

  task automatic finish_frame(output int lat);
    lat = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (ap_done) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout: got no ap_done expected ap_done within 3000 cycles");
    end else begin
      chk("ap_ready_pulse", 64'(ap_ready), 64'(1));
      repeat (3) @(negedge clk);
      chk("done_held", 64'(ap_done), 64'(1));
      chk("ready_one_cycle", 64'(ap_ready), 64'(0));
      chk("beats_consumed", 64'(beat_rd), 64'(beat_wr));
      chk("words_written", 64'(exp_rd), 64'(exp_wr));
      @(posedge clk); #1 ap_continue = 1;
      @(posedge clk); #1 ap_continue = 0;
      @(negedge clk);
      chk("done_cleared", 64'(ap_done), 64'(0));
      chk("idle_after", 64'(ap_idle), 64'(1));
    end
  endtask

  initial begin
    int lat, first, rows, cols, lbw, nrd;
    rst_n = 0; ap_start = 0; ap_continue = 0;
    rows_dout = '0; cols_dout = '0; last_blk_width = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    chk("rst_in_read", 64'(in_read), 64'(0));
    chk("rst_out_write", 64'(out_write), 64'(0));
    chk("rst_out_din", out_din, 64'(0));
    chk("rst_ap_done", 64'(ap_done), 64'(0));
    chk("rst_ap_ready", 64'(ap_ready), 64'(0));
    chk("rst_ap_idle", 64'(ap_idle), 64'(1));

    // Exact fill: 24 bytes -> three full words, no flush.
    load_beats(8, 1, first);
    push_exp(64'h0706050403020100, 0);
    push_exp(64'h0F0E0D0C0B0A0908, 0);
    push_exp(64'h1716151413121110, 1);
    start_frame(1, 8, 3);
    finish_frame(lat);

    // Partial last block: top byte of the last beat must be dropped.
    add_beat(24'hCCBBAA); add_beat(24'hFFEEDD); add_beat(24'h5A2211);
    push_exp(64'h2211FFEEDDCCBBAA, 1);
    start_frame(1, 3, 2);
    finish_frame(lat);

    // Tail flush: 112 bits over two rows.
    load_beats(6, 0, first);
    model_frame(first, 2, 3, 1);
    start_frame(2, 3, 1);
    finish_frame(lat);

    // Backpressure at the first emit point.
    force_full = 1;
    load_beats(8, 1, first);
    push_exp(64'h0706050403020100, 0);
    push_exp(64'h0F0E0D0C0B0A0908, 0);
    push_exp(64'h1716151413121110, 1);
    start_frame(1, 8, 3);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_read", 64'(in_read), 64'(0));
      chk("bp_out_write", 64'(out_write), 64'(0));
      chk("bp_out_din", out_din, 64'h0706050403020100);
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1 force_full = 0;
    finish_frame(lat);

    // Degenerate configurations.
    start_frame(0, 5, 3);
    finish_frame(lat);
    chk("degen_rows_latency", 64'(lat >= 0 && lat <= 1), 64'(1));
    start_frame(2, 0, 1);
    finish_frame(lat);
    chk("degen_cols_latency", 64'(lat >= 0 && lat <= 1), 64'(1));

    // Reset mid-frame after four beats.
    load_beats(12, 0, first);
    model_frame(first, 2, 6, 2);
    start_frame(2, 6, 2);
    nrd = 0;
    for (int n = 0; n < 200 && nrd < 4; n++) begin
      @(negedge clk);
      if (in_read) nrd++;
    end
    chk("reset_reached_4_beats", 64'(nrd), 64'(4));
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_in_read", 64'(in_read), 64'(0));
    chk("mid_rst_out_write", 64'(out_write), 64'(0));
    chk("mid_rst_out_din", out_din, 64'(0));
    chk("mid_rst_ap_done", 64'(ap_done), 64'(0));
    chk("mid_rst_ap_ready", 64'(ap_ready), 64'(0));
    repeat (2) @(posedge clk);
    beat_floor = beat_wr;
    exp_floor = exp_wr;
    #3 rst_n = 1;
    @(negedge clk);
    chk("post_rst_idle", 64'(ap_idle), 64'(1));
    load_beats(7, 0, first);
    model_frame(first, 1, 7, 3);
    start_frame(1, 7, 3);
    finish_frame(lat);

    // Randomised frames with input gaps and output backpressure.
    for (int f = 0; f < 10; f++) begin
      rows = $urandom_range(1, 3);
      cols = $urandom_range(1, 7);
      lbw  = $urandom_range(0, 3);
      gap_en  = 1'($urandom_range(0, 1));
      bp_rand = 1'($urandom_range(0, 1));
      load_beats(rows * cols, 0, first);
      model_frame(first, rows, cols, lbw);
      start_frame(rows, cols, lbw);
      finish_frame(lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mat_stream_axis_packer.md
Name: mat_stream_axis_packer

Overview:
- Parametrised successor of the fixed 24-to-64-bit mat-to-AXI-stream converter.
- Consumes one NPC-pixel beat per cycle from a mat-stream FIFO and packs the valid pixel bits LSB-first into DATAW-bit words for the AXI-stream-side FIFO.
- Handles a partial last block per row and flushes a zero-padded tail word at end of frame.
- Sits between the pp_pipeline compute stages and the AXI-stream adapter; uses the ap_ctrl_chain handshake.

Parameters:
PIXW, 8, bits per pixel
NPC, 3, pixels per input beat; NPC*PIXW <= DATAW is required and checked at elaboration
DATAW, 64, output word width
ROWW, 16, rows field width
COLW, 16, column-beat count width

Ports:
ap_clk  in  1  clock
ap_rst_n  in  1  asynchronous active-low reset
ap_start  in  1  start request
ap_continue  in  1  clears held done
ap_done  out  1  frame complete
ap_idle  out  1  idle
ap_ready  out  1  accepts next start
in_dout  in  NPC*PIXW  pixel beat; pixel k occupies [k*PIXW +: PIXW]
in_empty_n  in  1  input FIFO non-empty
in_read  out  1  input pop
out_din  out  DATAW  packed word
out_full_n  in  1  output FIFO not full
out_write  out  1  output push
rows_dout  in  ROWW  rows per frame (config FIFO)
rows_empty_n  in  1  rows FIFO non-empty
rows_read  out  1  rows pop
cols_dout  in  COLW  input beats per row (config FIFO)
cols_empty_n  in  1  cols FIFO non-empty
cols_read  out  1  cols pop
last_blk_width  in  clog2(NPC+1)  valid pixels in last beat of each row; sampled at config latch

Behaviour:
- Reset: the clock is ap_clk; the reset is ap_rst_n, asynchronous and active-low. Reset asserted mid-frame discards the accumulator and counters; no flush occurs.
- Reset values: FSM=IDLE; accumulator, fill counter, row/col counters, done_reg all 0. All reads, writes, ap_done and ap_ready are 0. out_din is 0. ap_idle = !ap_start.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - When ap_start & rows_empty_n & cols_empty_n & !done_reg: pop both config FIFOs in the same cycle and latch rows, cols and last_blk_width.
  - last_blk_width==0 or >NPC is treated as NPC.
  - If rows==0 or cols==0, go to DONE; otherwise go to RUN.
- RUN, per cycle:
  - vbits = NPC*PIXW, or lbw*PIXW when col==cols-1.
  - cand = acc | (in_dout[vbits-1:0] << fill).
  - emit = fill+vbits >= DATAW.
  - stall = emit & !out_full_n.
  - in_read = in_empty_n & !stall.
  - On read:
    - If emit: out_write=1 and out_din=cand[DATAW-1:0] in the same cycle; acc=cand>>DATAW; fill=fill+vbits-DATAW.
    - Otherwise: acc=cand; fill+=vbits.
    - Then col increments. At cols-1, col wraps to 0 and row increments. The final beat of the frame moves the FSM to FLUSH.
  - Bits above fill in acc are always 0.
  - Throughput is 1 beat/cycle with no bubbles while both FIFOs are ready.
- FLUSH:
  - If fill==0, go to DONE immediately.
  - Otherwise: out_write=out_full_n, out_din=acc zero-padded. Wait while !out_full_n; on the write, clear acc and go to DONE.
- DONE:
  - ap_done=1 and ap_ready=1 for one cycle, then return to IDLE.
  - done_reg holds ap_done high until ap_continue; ap_continue in the same cycle clears it.
  - A new start is blocked while done_reg is set.
- Packing is continuous across row boundaries (no per-row padding) unless the optional feature is enabled.
- fill width: clog2(DATAW+1). Accumulator width: DATAW + NPC*PIXW.

Optional Feature:
- Macro MS2AS_ROW_ALIGN_EN.
- When defined:
  - At the end of each row, any nonzero residual fill is flushed as a zero-padded word before the next row's first read.
  - An extra port out_last (out, 1) is added. It is 1 on the final word of each row, including an aligned exact fill, and 0 otherwise.
  - RUN gains a ROWFLUSH state; row flush obeys the same out_full_n stall rule.
- When undefined: no out_last port and continuous packing.

Decomposition:
- Shared package mat_axis_pkg holds:
  - state enum;
  - function clog2;
  - localparams BEATW=NPC*PIXW and ACCW=DATAW+BEATW.
- One sub-module: mat_axis_bitpacker. It is purely combinational: acc, fill, beat, vbits in; cand, emit, next_fill out.
- The FSM and counters live in the top module.

Test Plan:
- Exact fill: rows=1, cols=8, lbw=3, bytes 0x00..0x17 -> 3 writes: 0x0706050403020100, 0x0F0E…08, 0x17…10; no flush.
- Partial last block: rows=1, cols=3, lbw=2, beats 0xCCBBAA, 0xFFEEDD, 0x??2211 -> one word 0x2211FFEEDDCCBBAA.
- Tail flush: rows=2, cols=3, lbw=1 -> 112 bits -> 2 writes, second with bits [63:48]=0. With MS2AS_ROW_ALIGN_EN -> 2 writes, each 56 valid bits, out_last=1 on both.
- Backpressure: hold out_full_n=0 for 5 cycles at an emit point -> in_read=0 throughout, out_din stable, no data lost.
- Degenerate config: rows=0 -> no in_read and no out_write; ap_done within 2 cycles of the start pop; held until ap_continue.
- Reset mid-frame: drop ap_rst_n after 4 beats -> outputs 0 immediately. Next frame output matches the golden model with no residue.
